mfe_led7seg_74hc595_scan_scheduler: RTL and testbench
=====================================================

Name: mfe_led7seg_74hc595_scan_scheduler

Overview:
- Refresh scheduler for an 8-digit multiplexed 7-segment module built on 74HC595 shift registers.
- Holds a host-writable digit buffer and decodes hex to active-low segment codes.
- Round-robins one digit per refresh slot, issuing 16-bit {segments, digit_select} words over a vld/rdy handshake to mfe_led7seg_74hc595_controller.
- Replaces ad-hoc counter/case sequencing in top-level designs.

Parameters:
NUM_DIGITS, 8, number of scanned digits (1..8); digit_select bit i drives digit i
REFRESH_DIV, 1000, clk cycles per digit slot; must be >= 2

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
en  input  1  scanning enable
wr_en  input  1  buffer write strobe, one entry per cycle
wr_addr  input  3  digit index to write; writes with wr_addr >= NUM_DIGITS are ignored
wr_data  input  5  {dp_on, hex_nibble[3:0]}
blank  input  8  per-digit blank mask, 1 = digit dark
dat  output  16  {seg[7:0] active-low with bit7 = dp, sel[7:0] one-hot}
vld  output  1  dat valid toward the shift controller
rdy  input  1  shift controller ready/accept
frame_done  output  1  one-cycle pulse when the last digit of a frame is accepted

Behaviour:
- Reset (async assert, sync release):
  - Buffer is all {0, 4'h0}; idx = 0; timer = 0; state = IDLE.
  - Outputs: vld = 0, frame_done = 0, dat = 16'hC001.
- Buffer write: on wr_en, entry[wr_addr] <= wr_data on the next edge. Writes are allowed in any state and never stall.
- Decode, active-low:
  - 0..F = C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.
  - dp_on clears bit7.
  - blank[idx] = 1 forces seg = 8'hFF, including dp.
  - sel = 8'h01 << idx, and is still sent for blanked digits.
- Timer: free-running 0..REFRESH_DIV-1 regardless of state. tick = 1 when timer == REFRESH_DIV-1; timer wraps to 0 on the same edge.
- FSM:
  - IDLE: if tick && en, then on that edge latch dat from entry[idx] and blank[idx], set vld = 1, and go to SEND. Latency is tick cycle -> vld high on the next cycle.
  - SEND: vld held at 1 and dat held stable until the cycle where vld && rdy. On that edge:
    - vld <= 0.
    - idx <= (idx == NUM_DIGITS-1) ? 0 : idx + 1.
    - frame_done <= 1 for one cycle if idx was NUM_DIGITS-1.
    - Go to IDLE.
- Boundary rules:
  - A tick that occurs while in SEND is dropped, not queued; the next transfer waits for the following tick.
  - Write to the digit currently in SEND: the in-flight dat is unchanged; the new value appears on that digit's next slot.
  - en deasserted in SEND: the transfer completes normally, then the FSM stays IDLE; idx is retained and resumes from there.
  - en deasserted in IDLE: no new vld.
  - blank changes apply only at the next latch.
  - rdy high while vld = 0 has no effect.
  - vld is never deasserted without acceptance, except by reset.
  - Reset mid-SEND: vld drops immediately (async), and idx and the buffer return to reset values.
  - NUM_DIGITS < 8: sel bits above NUM_DIGITS-1 are never set.

Test Plan:
- Reset with rdy tied high, en = 1, REFRESH_DIV = 4:
  - Words 16'hC001, C002, ..., C080 appear one per 4 cycles.
  - frame_done pulses after C080, then the sequence wraps to C001.
  - vld is high exactly 1 cycle per word.
- Write entries 0..7 = 0..7, dp_on on entry 3:
  - Frame shows C001 F902 A404 3008 9910 9220 8240 F880.
  - Write entry 0 = 5'h0A; the next frame's first word is 8801.
- blank = 8'h24, all entries 8: words for digits 2 and 5 are FF04 and FF20; all others are 80xx.
- rdy held low for 10 cycles with REFRESH_DIV = 4:
  - dat and vld stay constant through the stall.
  - Ticks during the stall are dropped.
  - After acceptance, the next vld occurs only on the next tick, and idx advances by 1 only.
- Write entry 2 while the digit-2 word is in SEND: in-flight dat is unchanged, and the new code appears in the next frame.
- Assert rst mid-SEND at idx = 5: vld drops the same cycle; after release the first word is C001.
- Deassert en mid-SEND at idx = 3: that word completes with no further vld. Re-enable and the next word is for idx 4, sel = 8'h10.

Source files
------------

// File: rtl/mfe_led7seg_74hc595_scan_scheduler.sv
// mfe_led7seg_74hc595_scan_scheduler
//
// Refresh scheduler for a multiplexed 7-segment display driven through
// 74HC595 shift registers. A host-writable digit buffer holds one
// {dp_on, hex} entry per digit. Once every REFRESH_DIV clocks the scheduler
// decodes the current digit into an active-low segment byte and a one-hot
// digit select. It then offers the 16-bit word to the shift controller over a
// vld/rdy handshake, and moves round-robin to the next digit.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset
//   en         : scanning enable
//   wr_en      : buffer write strobe (one entry per cycle)
//   wr_addr    : digit index to write; indices >= NUM_DIGITS are ignored
//   wr_data    : {dp_on, hex_nibble[3:0]}
//   blank      : per-digit blank mask, 1 = digit dark
//   dat        : {seg[7:0] active-low (bit7 = dp), sel[7:0] one-hot}
//   vld        : dat valid toward the shift controller
//   rdy        : shift controller accepts dat
//   frame_done : one-cycle pulse after the last digit of a frame is accepted

module mfe_led7seg_74hc595_scan_scheduler #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [4:0]  wr_data,
  input  logic [7:0]  blank,
  output logic [15:0] dat,
  output logic        vld,
  input  logic        rdy,
  output logic        frame_done
);

  localparam int          TW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(REFRESH_DIV - 1);
  localparam logic [2:0]  LAST_IDX  = 3'(NUM_DIGITS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] timer;
  logic          tick;
  logic [2:0]    idx, idx_n;
  logic [15:0]   dat_q, dat_n;
  logic          frame_done_n;
  logic [4:0]    buf_q [8];
  logic [4:0]    entry;
  logic [7:0]    seg;

  // Hex digit to active-low segment pattern. Bit 7 is the decimal point,
  // which is dark (1) in every code.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] h);
    logic [7:0] s;
    s = 8'hFF;
    case (h)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      4'hF: s = 8'h8E;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  // Digit buffer. Always eight physical entries so wr_addr and idx index it
  // directly; only entries below NUM_DIGITS are ever written or scanned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) buf_q[i] <= 5'd0;
    end else if (wr_en && (wr_addr <= LAST_IDX)) begin
      buf_q[wr_addr] <= wr_data;
    end
  end

  // Free-running slot timer, independent of the handshake state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (timer == TIMER_MAX) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  assign tick = (timer == TIMER_MAX);

  // Segment byte for the digit about to be latched. Blanking overrides both
  // the segments and the decimal point.
  always_comb begin
    entry = buf_q[idx];
    seg   = hex_to_seg(entry[3:0]);
    if (entry[4]) seg[7] = 1'b0;
    if (blank[idx]) seg = 8'hFF;
  end

  // Next-state logic. A tick seen while a word is still in flight is simply
  // not acted on, so missed slots are dropped rather than queued.
  always_comb begin
    state_n      = state;
    idx_n        = idx;
    dat_n        = dat_q;
    frame_done_n = 1'b0;
    case (state)
      IDLE: begin
        if (tick && en) begin
          dat_n   = {seg, 8'h01 << idx};
          state_n = SEND;
        end
      end
      SEND: begin
        if (rdy) begin
          idx_n        = (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
          frame_done_n = (idx == LAST_IDX);
          state_n      = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State registers. The dat reset value is the decode of an all-zero
  // buffer entry for digit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= 3'd0;
      dat_q      <= 16'hC001;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      dat_q      <= dat_n;
      frame_done <= frame_done_n;
    end
  end

  // vld comes straight from the state register, so an async reset drops it
  // in the same cycle.
  assign vld = (state == SEND);
  assign dat = dat_q;

endmodule

// File: tb/tb_mfe_led7seg_74hc595_scan_scheduler.sv
// Testbench for mfe_led7seg_74hc595_scan_scheduler (NUM_DIGITS = 8,
// REFRESH_DIV = 4). A transaction-level model tracks the expected word,
// vld and frame_done, and is compared against the design every cycle.
// Directed scenarios pin the model with hand-computed words, and a random
// phase follows them.

module tb_mfe_led7seg_74hc595_scan_scheduler;

  localparam int ND  = 8;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b1;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = 3'd0;
  logic [4:0]  wr_data = 5'd0;
  logic [7:0]  blank = 8'h00;
  logic [15:0] dat;
  logic        vld;
  logic        rdy = 1'b1;
  logic        frame_done;

  int errors = 0;
  int checks = 0;
  bit started = 1'b0;

  mfe_led7seg_74hc595_scan_scheduler #(
    .NUM_DIGITS (ND),
    .REFRESH_DIV(DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .blank     (blank),
    .dat       (dat),
    .vld       (vld),
    .rdy       (rdy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]  segTab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [4:0]  mBuf [8];
  int          mTimer;
  int          mIdx;
  bit          mBusy;
  bit          mFd;
  logic [15:0] mDat;

  function automatic logic [15:0] modelWord(input logic [4:0] e, input bit bl, input int d);
    logic [7:0] s;
    s = segTab[e[3:0]];
    if (e[4]) s = s - 8'h80;
    if (bl) s = 8'hFF;
    return {s, 8'(1 << d)};
  endfunction

  // Slot-level model: a slot boundary starts a transfer when idle and enabled;
  // an outstanding transfer ends when the controller is ready.
  always @(posedge clk or posedge rst) begin : model
    bit slotEnd;
    if (rst) begin
      for (int i = 0; i < 8; i++) mBuf[i] = 5'd0;
      mTimer = 0;
      mIdx   = 0;
      mBusy  = 1'b0;
      mFd    = 1'b0;
      mDat   = 16'hC001;
    end else begin
      slotEnd = (mTimer == DIV - 1);
      mFd = 1'b0;
      if (mBusy && rdy) begin
        mFd   = (mIdx == ND - 1);
        mIdx  = (mIdx + 1) % ND;
        mBusy = 1'b0;
      end else if (!mBusy && slotEnd && en) begin
        mDat  = modelWord(mBuf[mIdx], blank[mIdx], mIdx);
        mBusy = 1'b1;
      end
      if (wr_en && int'(wr_addr) < ND) mBuf[wr_addr] = wr_data;
      mTimer = (mTimer + 1) % DIV;
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (started && !rst) begin
      checkOutput("model_vld", {15'd0, vld}, {15'd0, mBusy});
      checkOutput("model_dat", dat, mDat);
      checkOutput("model_frame_done", {15'd0, frame_done}, {15'd0, mFd});
    end
  end

  // Drive one cycle of buffer-write stimulus, starting just after a negedge
  task automatic applyStimulus(input bit we, input logic [2:0] a, input logic [4:0] d);
    wr_en   = we;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // Wait (bounded) for a negedge with vld high and return the word
  task automatic waitWord(output logic [15:0] w);
    bit ok;
    ok = 1'b0;
    w  = 16'hxxxx;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (vld) begin
        ok = 1'b1;
        w  = dat;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_vld: got no vld expected vld within 40 cycles at %0t", $time);
    end
  endtask

  // Wait for the word addressed to a given select bit
  task automatic waitSel(input logic [7:0] sel, output logic [15:0] w);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      waitWord(w);
      if (w[7:0] == sel) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_sel: got %h expected sel %h", w[7:0], sel);
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stim
    logic [15:0] w;
    logic [15:0] exp3 [8];
    int vldCount;
    exp3 = '{16'hF902, 16'hA404, 16'h3008, 16'h9910, 16'h9220, 16'h8240, 16'hF880, 16'hC001};

    // Reset with rdy high and scanning enabled
    #3 rst = 1'b1;
    #4 checkOutput("reset_dat", dat, 16'hC001);
    checkOutput("reset_vld", {15'd0, vld}, 16'd0);
    checkOutput("reset_frame_done", {15'd0, frame_done}, 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    started = 1'b1;
    $display("[TB] reset released");

    // Empty buffer: C001..C080, frame_done, then wrap to C001
    for (int k = 0; k < 9; k++) begin
      waitWord(w);
      checkOutput("frame_blank_buf", w, {8'hC0, 8'(1 << (k % 8))});
      if (k == 7) begin
        @(negedge clk);
        checkOutput("frame_done_pulse", {15'd0, frame_done}, 16'd1);
      end
    end
    en = 1'b0;

    // Entries 0..7 = 0..7, dp on entry 3; scanning resumes at digit 1
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, 3'(i), (i == 3) ? 5'h13 : 5'(i));
    en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      waitWord(w);
      checkOutput("decode_frame", w, exp3[k]);
    end
    applyStimulus(1'b1, 3'd0, 5'h0A);
    for (int k = 0; k < 8; k++) waitWord(w);
    checkOutput("rewrite_entry0", w, 16'h8801);
    en = 1'b0;

    // Blank digits 2 and 5 with every entry = 8
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 3'(i), 5'h08);
    blank = 8'h24;
    en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      int d;
      d = (1 + k) % 8;
      waitWord(w);
      checkOutput("blank_frame", w, {(d == 2 || d == 5) ? 8'hFF : 8'h80, 8'(1 << d)});
    end

    // Stall: rdy low for 10 cycles on the digit-1 word
    applyStimulus(1'b0, 3'd0, 5'd0);
    rdy = 1'b0;
    waitWord(w);
    checkOutput("stall_word", w, 16'h8002);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("stall_vld", {15'd0, vld}, 16'd1);
      checkOutput("stall_dat", dat, 16'h8002);
    end
    rdy = 1'b1;
    waitWord(w);
    checkOutput("after_stall_next_digit", w, 16'hFF04);

    // Write entry 2 while its word is in flight
    blank = 8'h00;
    waitSel(8'h04, w);
    rdy = 1'b0;
    checkOutput("inflight_before_write", w, 16'h8004);
    applyStimulus(1'b1, 3'd2, 5'h1F);
    @(negedge clk);
    checkOutput("inflight_after_write", dat, 16'h8004);
    rdy = 1'b1;
    @(negedge clk);
    waitSel(8'h04, w);
    checkOutput("rewritten_entry2", w, 16'h0E04);

    // Reset in the middle of the digit-5 transfer
    waitSel(8'h20, w);
    rdy = 1'b0;
    #2 rst = 1'b1;
    #1 checkOutput("async_reset_vld", {15'd0, vld}, 16'd0);
    checkOutput("async_reset_dat", dat, 16'hC001);
    @(negedge clk);
    rst = 1'b0;
    rdy = 1'b1;
    waitWord(w);
    checkOutput("post_reset_first", w, 16'hC001);

    // Disable scanning while the digit-3 word is in flight
    waitSel(8'h08, w);
    rdy = 1'b0;
    en  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rdy = 1'b1;
    @(negedge clk);
    vldCount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (vld) vldCount++;
    end
    checkOutput("disabled_no_vld", 16'(vldCount), 16'd0);
    en = 1'b1;
    waitWord(w);
    checkOutput("resume_idx4", w, 16'hC010);

    // Randomized traffic checked cycle by cycle against the model
    for (int i = 0; i < 800; i++) begin
      en      = ($urandom_range(0, 7) != 0);
      rdy     = ($urandom_range(0, 2) != 0);
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = 3'($urandom_range(0, 7));
      wr_data = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 15) == 0) blank = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    wr_en = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
